mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between the core's instruction-fetch channel and its load/store channel.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_arb_rr2.sv | 19 +
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
// State encoding, owner codes and timer sizing helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   localparam logic ARB_OWNER_FETCH = 1'b0;
   localparam logic ARB_OWNER_DATA  = 1'b1;

   function automatic int timer_width(input int t);
      return (t > 1) ? $clog2(t) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin picker, purely combinational.
// req[0]=fetch, req[1]=data; a tie goes to the side not granted last.
module arb_rr2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // One-hot grant; contention resolved against the previous winner
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = (last_grant == ARB_OWNER_FETCH) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction outstanding; watchdog aborts responses that never come.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   output logic                  i_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   output logic                  i_resp_valid,
   output logic [DATA_WIDTH-1:0] i_resp_data,
   output logic                  i_resp_err,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic                  d_req_write,
   input  logic [ADDR_WIDTH-1:0] d_req_addr,
   input  logic [DATA_WIDTH-1:0] d_req_wdata,
   input  logic [STRB_WIDTH-1:0] d_req_wstrb,
   output logic                  d_resp_valid,
   output logic [DATA_WIDTH-1:0] d_resp_data,
   output logic                  d_resp_err,
   output logic                  m_req_valid,
   input  logic                  m_req_ready,
   output logic                  m_req_write,
   output logic [ADDR_WIDTH-1:0] m_req_addr,
   output logic [DATA_WIDTH-1:0] m_req_wdata,
   output logic [STRB_WIDTH-1:0] m_req_wstrb,
   input  logic                  m_resp_valid,
   input  logic [DATA_WIDTH-1:0] m_resp_data,
   output logic                  owner
);

   localparam int TW = timer_width(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   arb_state_t    state;
   logic          last_grant;
   logic [TW-1:0] timer;
   logic [1:0]    grant;
   logic          idle;
   logic          in_resp;
   logic          expire;
   logic          fin;
   logic          fin_i;
   logic          fin_d;

   arb_rr2 u_rr (
      .req        ({d_req_valid, i_req_valid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Handshake and response routing; everything held low during reset
   always_comb begin
      idle    = rst && (state == ARB_IDLE);
      in_resp = rst && (state == ARB_RESP);
      expire  = (TIMEOUT != 0) && (timer == T_LAST) && !m_resp_valid;
      fin     = in_resp && (m_resp_valid || expire);
      fin_i   = fin && (owner == ARB_OWNER_FETCH);
      fin_d   = fin && (owner == ARB_OWNER_DATA);

      i_req_ready  = idle && grant[0];
      d_req_ready  = idle && grant[1];

      i_resp_valid = fin_i;
      i_resp_err   = fin_i && expire;
      i_resp_data  = '0;
      if (fin_i && m_resp_valid) begin
         i_resp_data = m_resp_data;
      end

      d_resp_valid = fin_d;
      d_resp_err   = fin_d && expire;
      d_resp_data  = '0;
      if (fin_d && m_resp_valid && !m_req_write) begin
         d_resp_data = m_resp_data;
      end
   end

   // Transaction FSM with payload, owner, fairness and watchdog state
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ARB_IDLE;
         last_grant  <= ARB_OWNER_FETCH;
         timer       <= '0;
         owner       <= ARB_OWNER_FETCH;
         m_req_valid <= 1'b0;
         m_req_write <= 1'b0;
         m_req_addr  <= '0;
         m_req_wdata <= '0;
         m_req_wstrb <= '0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (|grant) begin
                  owner       <= grant[1];
                  last_grant  <= grant[1];
                  m_req_valid <= 1'b1;
                  state       <= ARB_REQ;
                  if (grant[1]) begin
                     m_req_write <= d_req_write;
                     m_req_addr  <= d_req_addr;
                     m_req_wdata <= d_req_wdata;
                     m_req_wstrb <= d_req_wstrb;
                  end else begin
                     m_req_write <= 1'b0;
                     m_req_addr  <= i_req_addr;
                     m_req_wdata <= '0;
                     m_req_wstrb <= '0;
                  end
               end
            end
            ARB_REQ: begin
               if (m_req_ready) begin
                  m_req_valid <= 1'b0;
                  timer       <= '0;
                  state       <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (m_resp_valid || expire) begin
                  state <= ARB_IDLE;
               end else if (timer != '1) begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a scripted memory model.
// Expected responses are queued at request accept and popped by a monitor.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        ch;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        i_req_valid;
   logic        i_req_ready;
   logic [31:0] i_req_addr;
   logic        i_resp_valid;
   logic [31:0] i_resp_data;
   logic        i_resp_err;
   logic        d_req_valid;
   logic        d_req_ready;
   logic        d_req_write;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic [3:0]  d_req_wstrb;
   logic        d_resp_valid;
   logic [31:0] d_resp_data;
   logic        d_resp_err;
   logic        m_req_valid;
   logic        m_req_ready;
   logic        m_req_write;
   logic [31:0] m_req_addr;
   logic [31:0] m_req_wdata;
   logic [3:0]  m_req_wstrb;
   logic        m_resp_valid;
   logic [31:0] m_resp_data;
   logic        owner;

   int   n_cmp;
   int   n_bad;
   exp_t sb[$];
   int   grant_log[$];

   int cfg_lat;
   int cfg_stall;
   int cfg_noresp;

   int          mm_hs;
   int          mm_pend;
   int          mm_cnt;
   int          mm_stall;
   logic [31:0] mm_ha;
   logic [31:0] mm_pa;

   mem_port_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .STRB_WIDTH (4),
      .TIMEOUT    (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (i_req_valid),
      .i_req_ready  (i_req_ready),
      .i_req_addr   (i_req_addr),
      .i_resp_valid (i_resp_valid),
      .i_resp_data  (i_resp_data),
      .i_resp_err   (i_resp_err),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_req_write  (d_req_write),
      .d_req_addr   (d_req_addr),
      .d_req_wdata  (d_req_wdata),
      .d_req_wstrb  (d_req_wstrb),
      .d_resp_valid (d_resp_valid),
      .d_resp_data  (d_resp_data),
      .d_resp_err   (d_resp_err),
      .m_req_valid  (m_req_valid),
      .m_req_ready  (m_req_ready),
      .m_req_write  (m_req_write),
      .m_req_addr   (m_req_addr),
      .m_req_wdata  (m_req_wdata),
      .m_req_wstrb  (m_req_wstrb),
      .m_resp_valid (m_resp_valid),
      .m_resp_data  (m_resp_data),
      .owner        (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0000_0013 : a + 32'h1000_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req_i(input logic [31:0] a, input logic [31:0] ed,
                        input logic ee, input bit want);
      bit ok;
      exp_t e;
      ok = 1'b0;
      i_req_valid = 1'b1;
      i_req_addr  = a;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (i_req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         if (want) begin
            e.ch = 1'b0; e.data = ed; e.err = ee;
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
      end else begin
         chk("i_ready_timeout", 32'(i_req_ready), 32'd1);
      end
      i_req_valid = 1'b0;
   endtask

   task automatic req_d(input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] ed, input logic ee,
                        input bit want);
      bit ok;
      exp_t e;
      ok = 1'b0;
      d_req_valid = 1'b1;
      d_req_write = w;
      d_req_addr  = a;
      d_req_wdata = wd;
      d_req_wstrb = ws;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (d_req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         if (want) begin
            e.ch = 1'b1; e.data = ed; e.err = ee;
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
      end else begin
         chk("d_ready_timeout", 32'(d_req_ready), 32'd1);
      end
      d_req_valid = 1'b0;
   endtask

   // memory model: stalls ready, answers after cfg_lat cycles or never
   initial begin
      m_req_ready  = 1'b0;
      m_resp_valid = 1'b0;
      m_resp_data  = '0;
      mm_pend  = 0;
      mm_cnt   = 0;
      mm_stall = 0;
      forever begin
         @(negedge clk);
         mm_hs = int'(rst && m_req_valid && m_req_ready);
         mm_ha = m_req_addr;
         @(posedge clk);
         #1;
         m_resp_valid = 1'b0;
         m_resp_data  = '0;
         if (mm_hs != 0) begin
            mm_pend = 1;
            mm_cnt  = cfg_lat;
            mm_pa   = mm_ha;
         end
         if (mm_pend != 0 && cfg_noresp != 0) begin
            mm_pend = 0;
         end else if (mm_pend != 0) begin
            if (mm_cnt <= 1) begin
               m_resp_valid = 1'b1;
               m_resp_data  = mem_rd(mm_pa);
               mm_pend = 0;
            end else begin
               mm_cnt--;
            end
         end
         if (m_req_valid) begin
            if (mm_stall < cfg_stall) begin
               m_req_ready = 1'b0;
               mm_stall++;
            end else begin
               m_req_ready = 1'b1;
            end
         end else begin
            m_req_ready = 1'b0;
            mm_stall = 0;
         end
      end
   end

   // response monitor: pops the scoreboard on every response pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && (i_resp_valid || d_resp_valid)) begin
            if (sb.size() == 0) begin
               chk("resp_unexpected", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("resp_both", 32'(i_resp_valid & d_resp_valid), 32'd0);
               chk("resp_channel", 32'(d_resp_valid), 32'(e.ch));
               chk("resp_data", d_resp_valid ? d_resp_data : i_resp_data,
                   e.data);
               chk("resp_err", 32'(d_resp_valid ? d_resp_err : i_resp_err),
                   32'(e.err));
            end
         end
      end
   end

   // grant logger and ready exclusivity
   initial begin
      forever begin
         @(negedge clk);
         if (rst && (i_req_ready || d_req_ready)) begin
            chk("ready_onehot", 32'(i_req_ready & d_req_ready), 32'd0);
            if (i_req_valid && i_req_ready) grant_log.push_back(0);
            if (d_req_valid && d_req_ready) grant_log.push_back(1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: got running expected finished");
      $fatal(1, "simulation time bound exceeded");
   end

   initial begin
      int n;
      int pulses;
      int strays;
      n_cmp = 0;
      n_bad = 0;
      cfg_lat = 1;
      cfg_stall = 0;
      cfg_noresp = 0;
      rst = 1'b0;
      i_req_valid = 1'b0;
      i_req_addr  = '0;
      d_req_valid = 1'b0;
      d_req_write = 1'b0;
      d_req_addr  = '0;
      d_req_wdata = '0;
      d_req_wstrb = '0;

      // reset state
      @(posedge clk);
      @(negedge clk);
      chk("rst_m_req_valid", 32'(m_req_valid), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_resp", 32'({i_resp_valid, d_resp_valid}), 32'd0);
      chk("rst_m_req_addr", m_req_addr, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_cyc(2);

      // fetch only, with stale store payload on the idle data channel
      d_req_write = 1'b1;
      d_req_wdata = 32'hFFFF_FFFF;
      d_req_wstrb = 4'hF;
      req_i(32'h100, 32'h0000_0013, 1'b0, 1'b1);
      @(negedge clk);
      chk("fetch_m_valid", 32'(m_req_valid), 32'd1);
      chk("fetch_m_addr", m_req_addr, 32'h100);
      chk("fetch_m_write", 32'(m_req_write), 32'd0);
      chk("fetch_m_wstrb", 32'(m_req_wstrb), 32'd0);
      chk("fetch_m_wdata", m_req_wdata, 32'd0);
      chk("fetch_owner", 32'(owner), 32'd0);
      @(negedge clk);
      chk("fetch_latency", 32'(i_resp_valid), 32'd1);
      wait_cyc(3);

      // simultaneous requests held: grants alternate D,I,D,I
      grant_log.delete();
      fork
         begin
            repeat (2) req_i(32'h200, 32'h1000_0200, 1'b0, 1'b1);
         end
         begin
            repeat (2) req_d(1'b0, 32'h400, 32'h0, 4'h0,
                             32'h1000_0400, 1'b0, 1'b1);
         end
      join
      wait_cyc(4);
      chk("rr_count", 32'(grant_log.size()), 32'd4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
         chk("rr_order", 32'(grant_log[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
      end

      // store with memory stalling ready for three cycles
      cfg_stall = 3;
      req_d(1'b1, 32'h80, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("st_m_valid", 32'(m_req_valid), 32'd1);
         chk("st_m_ready", 32'(m_req_ready), 32'd0);
         chk("st_m_addr", m_req_addr, 32'h80);
         chk("st_m_wdata", m_req_wdata, 32'hDEAD_BEEF);
         chk("st_m_wstrb", 32'(m_req_wstrb), 32'hF);
         chk("st_m_write", 32'(m_req_write), 32'd1);
      end
      wait_cyc(5);
      cfg_stall = 0;

      // watchdog: memory never answers a load
      cfg_noresp = 1;
      req_d(1'b0, 32'h300, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         n = k;
         if (d_resp_valid) break;
      end
      chk("wd_latency", 32'(n), 32'd5);
      wait_cyc(1);
      cfg_noresp = 0;
      req_i(32'h104, 32'h1000_0104, 1'b0, 1'b1);
      wait_cyc(4);

      // response lands on the expiry cycle: data wins, no error
      cfg_lat = 4;
      req_i(32'h108, 32'h1000_0108, 1'b0, 1'b1);
      wait_cyc(8);
      cfg_lat = 1;

      // reset while waiting in RESP, then a stray late response
      cfg_lat = 6;
      req_d(1'b0, 32'h700, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      i_req_valid = 1'b1;
      i_req_addr  = 32'h900;
      @(negedge clk);
      chk("rr_rst_ready", 32'({i_req_ready, d_req_ready}), 32'd0);
      chk("rr_rst_owner", 32'(owner), 32'd0);
      chk("rr_rst_m_valid", 32'(m_req_valid), 32'd0);
      chk("rr_rst_m_addr", m_req_addr, 32'd0);
      chk("rr_rst_resp", 32'({i_resp_valid, d_resp_valid,
                              i_resp_err, d_resp_err}), 32'd0);
      i_req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      cfg_lat = 1;
      pulses = 0;
      strays = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (i_resp_valid || d_resp_valid) pulses++;
         if (m_resp_valid) strays++;
         if (m_req_valid) pulses++;
      end
      chk("stray_no_pulse", 32'(pulses), 32'd0);
      chk("stray_seen", 32'(strays), 32'd1);
      wait_cyc(1);

      // first tie after reset goes to data
      grant_log.delete();
      fork
         req_i(32'h500, 32'h1000_0500, 1'b0, 1'b1);
         req_d(1'b0, 32'h600, 32'h0, 4'h0, 32'h1000_0600, 1'b0, 1'b1);
      join
      wait_cyc(4);
      chk("rst_tie_count", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() >= 2) begin
         chk("rst_tie_first", 32'(grant_log[0]), 32'd1);
         chk("rst_tie_second", 32'(grant_log[1]), 32'd0);
      end

      wait_cyc(6);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
